// File: rtl/wb_ram_burst_pkg.sv
// rtl/wb_ram_burst_pkg.sv - shared Wishbone cycle/burst codes and FSM encoding for wb_ram_burst
package wb_ram_burst_pkg;

   // Default bus widths used by the Wishbone slaves in this slice
   localparam int unsigned WB_DATA_W_DEFAULT = 32;
   localparam int unsigned WB_ADDR_W_DEFAULT = 32;

   // Cycle type identifiers (wb_cti_i)
   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

   // Burst type extensions (wb_bte_i)
   localparam logic [1:0] BTE_LINEAR  = 2'b00;
   localparam logic [1:0] BTE_WRAP4   = 2'b01;
   localparam logic [1:0] BTE_WRAP8   = 2'b10;
   localparam logic [1:0] BTE_WRAP16  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_ACK   = 2'd2,
      ST_BURST = 2'd3
   } state_e;

   // Mask of the word-index bits that advance inside a wrapping burst; 0 means linear
   function automatic logic [3:0] wrap_mask(input logic [1:0] bte);
      logic [3:0] m;
      case (bte)
         BTE_WRAP4:  m = 4'h3;
         BTE_WRAP8:  m = 4'h7;
         BTE_WRAP16: m = 4'hF;
         BTE_LINEAR: m = 4'h0;
         default:    m = 4'h0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/wb_ram_core.sv
// rtl/wb_ram_core.sv - single-port RAM with byte enables and a registered read port
module wb_ram_core
   import wb_ram_burst_pkg::*;
#(
   parameter int unsigned DATA_W     = WB_DATA_W_DEFAULT,
   parameter int unsigned DEPTH_LOG2 = 12
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  we_i,
   input  logic [DATA_W/8-1:0]   sel_i,
   input  logic [DEPTH_LOG2-1:0] addr_i,
   input  logic [DATA_W-1:0]     wdata_i,
   output logic [DATA_W-1:0]     rdata_o
);

   localparam int unsigned SEL_W = DATA_W / 8;
   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   // Byte-lane write; lanes with a cleared select keep their old contents
   always_ff @(posedge clk) begin
      if (we_i) begin
         for (int i = 0; i < SEL_W; i++) begin
            if (sel_i[i]) begin
               mem_q[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
            end
         end
      end
   end

   // Registered read (old data on a same-cycle write); only the output register is reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/wb_ram_burst.sv
// rtl/wb_ram_burst.sv - Wishbone RAM slave with wait states, linear/wrap bursts and range error
module wb_ram_burst
   import wb_ram_burst_pkg::*;
#(
   parameter int unsigned DATA_W      = WB_DATA_W_DEFAULT,
   parameter int unsigned ADDR_W      = WB_ADDR_W_DEFAULT,
   parameter int unsigned DEPTH_LOG2  = 12,
   parameter int unsigned WAIT_STATES = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [ADDR_W-1:0]   wb_adr_i,
   input  logic [DATA_W-1:0]   wb_dat_i,
   input  logic                wb_we_i,
   input  logic [DATA_W/8-1:0] wb_sel_i,
   input  logic                wb_stb_i,
   input  logic                wb_cyc_i,
   input  logic [2:0]          wb_cti_i,
   input  logic [1:0]          wb_bte_i,
   output logic [DATA_W-1:0]   wb_dat_o,
   output logic                wb_ack_o,
   output logic                wb_err_o
);

   localparam int unsigned B  = $clog2(DATA_W / 8);
   localparam logic [2:0]  WS = 3'(WAIT_STATES);

   state_e                state_q, state_d;
   logic [2:0]            cnt_q, cnt_d;
   logic [DEPTH_LOG2-1:0] addr_q, addr_d;
   logic                  oor_q, oor_d;

   logic                  req;
   logic                  active;
   logic [DEPTH_LOG2-1:0] adr_idx;
   logic                  adr_oor;
   logic [DEPTH_LOG2-1:0] wmask;
   logic [DEPTH_LOG2-1:0] addr_inc;
   logic [DEPTH_LOG2-1:0] addr_next;
   logic                  ram_we;
   logic [DEPTH_LOG2-1:0] ram_addr;

   assign req     = wb_cyc_i & wb_stb_i;
   assign adr_idx = wb_adr_i[DEPTH_LOG2+B-1:B];
   assign adr_oor = (wb_adr_i >> (DEPTH_LOG2 + B)) != '0;

   // Next burst word index: wrap bursts only advance the low index bits
   always_comb begin
      wmask    = DEPTH_LOG2'(wrap_mask(wb_bte_i));
      addr_inc = addr_q + 1'b1;
      if (wb_bte_i == BTE_LINEAR) begin
         addr_next = addr_inc;
      end else begin
         addr_next = (addr_q & ~wmask) | (addr_inc & wmask);
      end
   end

   // Responses are gated by the live request so they vanish the cycle it drops
   assign active   = (state_q == ST_ACK) || (state_q == ST_BURST);
   assign wb_ack_o = active & req & ~oor_q;
   assign wb_err_o = active & req & oor_q;

   // Writes use the current beat address; otherwise the port prefetches the next beat
   assign ram_we   = wb_ack_o & wb_we_i;
   assign ram_addr = ram_we ? addr_q : addr_d;

   // Next-state, wait counter and beat address
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      oor_d   = oor_q;
      case (state_q)
         ST_IDLE: begin
            cnt_d  = 3'd0;
            addr_d = adr_idx;
            oor_d  = adr_oor;
            if (req) begin
               if (WAIT_STATES == 0) begin
                  state_d = ST_ACK;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = 3'd1;
               end
            end
         end
         ST_WAIT: begin
            addr_d = adr_idx;
            oor_d  = adr_oor;
            if (!req) begin
               state_d = ST_IDLE;
               cnt_d   = 3'd0;
            end else if (cnt_q == WS) begin
               state_d = ST_ACK;
               cnt_d   = 3'd0;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         ST_ACK, ST_BURST: begin
            cnt_d = 3'd0;
            if (!req) begin
               state_d = ST_IDLE;
            end else begin
               addr_d = addr_next;
               case (wb_cti_i)
                  CTI_INCR:             state_d = ST_BURST;
                  CTI_CLASSIC, CTI_EOB: state_d = ST_IDLE;
                  default:              state_d = ST_IDLE;
               endcase
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 3'd0;
         end
      endcase
   end

   // State register with asynchronous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= 3'd0;
         addr_q  <= '0;
         oor_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         oor_q   <= oor_d;
      end
   end

   wb_ram_core #(
      .DATA_W     (DATA_W),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_ram (
      .clk     (clk),
      .rst_n   (rst_n),
      .we_i    (ram_we),
      .sel_i   (wb_sel_i),
      .addr_i  (ram_addr),
      .wdata_i (wb_dat_i),
      .rdata_o (wb_dat_o)
   );

endmodule

// File: tb/tb_wb_ram_burst.sv
// tb/tb_wb_ram_burst.sv - randomized self-checking bench for wb_ram_burst against a word-array model
module tb_wb_ram_burst;
   import wb_ram_burst_pkg::*;

   localparam int WS = 2;
   localparam int DL = 12;
   localparam int NW = 1 << DL;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [31:0] wb_adr_i = '0;
   logic [31:0] wb_dat_i = '0;
   logic        wb_we_i = 1'b0;
   logic [3:0]  wb_sel_i = '0;
   logic        wb_stb_i = 1'b0;
   logic        wb_cyc_i = 1'b0;
   logic [2:0]  wb_cti_i = '0;
   logic [1:0]  wb_bte_i = '0;
   logic [31:0] wb_dat_o;
   logic        wb_ack_o;
   logic        wb_err_o;

   int          n_tests = 0;
   int          n_fail = 0;
   logic [31:0] model [int];
   logic [31:0] last_rd;

   always #5 clk = ~clk;

   wb_ram_burst #(
      .DATA_W      (32),
      .ADDR_W      (32),
      .DEPTH_LOG2  (DL),
      .WAIT_STATES (WS)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .wb_adr_i (wb_adr_i),
      .wb_dat_i (wb_dat_i),
      .wb_we_i  (wb_we_i),
      .wb_sel_i (wb_sel_i),
      .wb_stb_i (wb_stb_i),
      .wb_cyc_i (wb_cyc_i),
      .wb_cti_i (wb_cti_i),
      .wb_bte_i (wb_bte_i),
      .wb_dat_o (wb_dat_o),
      .wb_ack_o (wb_ack_o),
      .wb_err_o (wb_err_o)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Word touched by beat i of a burst starting at word 'start'
   function automatic int beat_word(input int start, input int i, input logic [1:0] bt);
      int n;
      n = (bt == BTE_WRAP4) ? 4 : (bt == BTE_WRAP8) ? 8 : (bt == BTE_WRAP16) ? 16 : 0;
      if (n == 0) return (start + i) % NW;
      return (start / n) * n + ((start + i) % n);
   endfunction

   function automatic logic [31:0] beat_data(input logic [31:0] base, input int i);
      return base ^ (32'(i) * 32'h9E37_79B9);
   endfunction

   task automatic idle_bus();
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      wb_we_i  = 1'b0;
      wb_cti_i = CTI_CLASSIC;
      wb_bte_i = BTE_LINEAR;
      wb_sel_i = 4'h0;
   endtask

   task automatic bus_cycle(input bit w, input logic [31:0] adr, input int beats,
                            input logic [1:0] bt, input logic [3:0] s, input logic [31:0] wbase);
      int          lat;
      int          start;
      int          wd;
      bit          oor;
      logic [31:0] old;
      logic [31:0] d;
      start = int'(adr[13:2]);
      oor   = (adr[31:14] != 18'd0);
      @(posedge clk); #1;
      wb_cyc_i = 1'b1;
      wb_stb_i = 1'b1;
      wb_we_i  = w;
      wb_adr_i = adr;
      wb_sel_i = s;
      wb_bte_i = bt;
      wb_cti_i = (beats > 1) ? CTI_INCR : CTI_CLASSIC;
      wb_dat_i = beat_data(wbase, 0);
      @(negedge clk);
      lat = 0;
      while (!(wb_ack_o || wb_err_o) && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check_eq("latency", 32'(lat), 32'(WS + 1));
      for (int i = 0; i < beats; i++) begin
         wd = beat_word(start, i, bt);
         d  = beat_data(wbase, i);
         check_eq("ack", {31'd0, wb_ack_o}, {31'd0, !oor});
         check_eq("err", {31'd0, wb_err_o}, {31'd0, oor});
         if (!w) begin
            last_rd = wb_dat_o;
            if (!oor && model.exists(wd)) check_eq("rdata", wb_dat_o, model[wd]);
         end else if (!oor && (s == 4'hF || model.exists(wd))) begin
            old = model.exists(wd) ? model[wd] : 32'h0;
            for (int b = 0; b < 4; b++) if (s[b]) old[b*8 +: 8] = d[b*8 +: 8];
            model[wd] = old;
         end
         @(posedge clk); #1;
         if (i == beats - 1) begin
            idle_bus();
         end else begin
            wb_cti_i = (i + 1 == beats - 1) ? CTI_EOB : CTI_INCR;
            wb_dat_i = beat_data(wbase, i + 1);
         end
         @(negedge clk);
      end
      check_eq("ack_after", {31'd0, wb_ack_o}, 32'd0);
      check_eq("err_after", {31'd0, wb_err_o}, 32'd0);
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      bit          w;
      int          beats;
      int          start;
      logic [1:0]  bt;
      logic [3:0]  s;
      idle_bus();
      #2 rst_n = 1'b0;
      @(negedge clk);
      check_eq("reset_ack", {31'd0, wb_ack_o}, 32'd0);
      check_eq("reset_err", {31'd0, wb_err_o}, 32'd0);
      check_eq("reset_dat", wb_dat_o, 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;

      // Fill words 0..63 with linear 16-beat write bursts
      for (int k = 0; k < 4; k++) bus_cycle(1'b1, 32'(k * 64), 16, BTE_LINEAR, 4'hF, $urandom);

      // Classic write then read
      bus_cycle(1'b1, 32'h10, 1, BTE_LINEAR, 4'hF, 32'hDEAD_BEEF);
      bus_cycle(1'b0, 32'h10, 1, BTE_LINEAR, 4'hF, 32'h0);
      check_eq("classic_rd", last_rd, 32'hDEAD_BEEF);

      // Byte-lane merge
      bus_cycle(1'b1, 32'h40, 1, BTE_LINEAR, 4'hF, 32'hAABB_CCDD);
      bus_cycle(1'b1, 32'h40, 1, BTE_LINEAR, 4'b0101, 32'h1122_3344);
      bus_cycle(1'b0, 32'h40, 1, BTE_LINEAR, 4'hF, 32'h0);
      check_eq("sel_merge", last_rd, 32'hAA22_CC44);

      // Linear read burst from word 8, wrap4 read from word 6
      bus_cycle(1'b0, 32'h20, 4, BTE_LINEAR, 4'hF, 32'h0);
      bus_cycle(1'b0, 32'h18, 4, BTE_WRAP4, 4'hF, 32'h0);

      // Linear burst across the top of memory wraps to word 0
      bus_cycle(1'b1, 32'h3FF8, 4, BTE_LINEAR, 4'hF, $urandom);
      bus_cycle(1'b0, 32'h3FF8, 4, BTE_LINEAR, 4'hF, 32'h0);
      bus_cycle(1'b0, 32'h0, 2, BTE_LINEAR, 4'hF, 32'h0);

      // Out-of-range write must error and leave word 0 untouched
      bus_cycle(1'b1, 32'h0001_0000, 1, BTE_LINEAR, 4'hF, 32'h5555_AAAA);
      bus_cycle(1'b0, 32'h0001_0000, 1, BTE_LINEAR, 4'hF, 32'h0);
      bus_cycle(1'b0, 32'h0, 1, BTE_LINEAR, 4'hF, 32'h0);

      // Drop cyc during the wait states, then re-request immediately
      @(posedge clk); #1;
      wb_cyc_i = 1'b1;
      wb_stb_i = 1'b1;
      wb_we_i  = 1'b1;
      wb_adr_i = 32'h14;
      wb_sel_i = 4'hF;
      wb_cti_i = CTI_CLASSIC;
      wb_dat_i = 32'h0BAD_F00D;
      @(negedge clk);
      check_eq("drop_ack0", {31'd0, wb_ack_o}, 32'd0);
      @(posedge clk); #1 wb_cyc_i = 1'b0;
      @(negedge clk);
      check_eq("drop_ack1", {31'd0, wb_ack_o}, 32'd0);
      bus_cycle(1'b0, 32'h14, 1, BTE_LINEAR, 4'hF, 32'h0);

      // Randomized traffic inside the pre-filled window
      for (int n = 0; n < 30; n++) begin
         w     = 1'($urandom_range(0, 1));
         bt    = 2'($urandom_range(0, 3));
         beats = 1 << $urandom_range(0, 4);
         start = (bt == BTE_LINEAR) ? int'($urandom_range(0, 64 - beats)) : int'($urandom_range(0, 63));
         s     = w ? 4'($urandom_range(1, 15)) : 4'hF;
         bus_cycle(w, 32'(start * 4), beats, bt, s, $urandom);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
